// File: rtl/oam_dma_if.sv
// Bus bundle shared by the CPU, the sprite-DMA engine and the shared memory/PPU bus.
// The DMA engine sits on the master side and owns the shared bus.
interface oam_dma_if;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_o_data;
    logic        cpu_we;
    logic        cpu_locked;
    logic [7:0]  cpu_i_data;
    logic [15:0] mem_address;
    logic [7:0]  mem_i_data;
    logic [7:0]  mem_o_data;
    logic        mem_we;
    logic        busy;

    modport master (
        input  cpu_address, cpu_o_data, cpu_we, mem_i_data,
        output cpu_locked, cpu_i_data, mem_address, mem_o_data, mem_we, busy
    );

    modport slave (
        output cpu_address, cpu_o_data, cpu_we, mem_i_data,
        input  cpu_locked, cpu_i_data, mem_address, mem_o_data, mem_we, busy
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite-DMA engine: passes the CPU bus through while idle and copies one 256-byte page to the OAM port
// on a CPU write to 16'h4014. Define OAM_DMA_ALIGN_EN to add the parity-aligned ALIGN start-up state.
module oam_dma (
    input  logic      clock,
    input  logic      reset,
    input  logic      locked,
    oam_dma_if.master bus
);

    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_PORT = 16'h2004;

`ifdef OAM_DMA_ALIGN_EN
    typedef enum logic [1:0] {IDLE, ALIGN, READ, WRITE} state_t;
    localparam state_t FIRST = ALIGN;
`else
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    localparam state_t FIRST = READ;
`endif

    state_t     state;
    state_t     state_nx;
    logic [7:0] page;
    logic [7:0] idx;
    logic       busy_r;
    logic       we_q;
    logic       trigger;
    logic       last_byte;

    // Only a rising write strobe starts a copy, so a frozen CPU holding we high cannot retrigger.
    assign trigger   = locked & bus.cpu_we & ~we_q & (bus.cpu_address == DMA_REG) & (state == IDLE);
    assign last_byte = (idx == 8'hFF);

`ifdef OAM_DMA_ALIGN_EN
    logic parity;
    logic align_hold;
    logic align_stay;

    // A second ALIGN cycle is spent only when parity was 1 on the first one.
    assign align_stay = parity & ~align_hold;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity     <= 1'b0;
            align_hold <= 1'b0;
        end else if (locked) begin
            parity <= ~parity;
            if (trigger)
                align_hold <= 1'b0;
            else if (state == ALIGN && align_stay)
                align_hold <= 1'b1;
        end
    end
`endif

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else if (locked)
            state <= state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            page   <= 8'h00;
            idx    <= 8'h00;
            busy_r <= 1'b0;
            we_q   <= 1'b0;
        end else if (locked) begin
            we_q <= bus.cpu_we;
            if (trigger) begin
                page   <= bus.cpu_o_data;
                idx    <= 8'h00;
                busy_r <= 1'b1;
            end else if (state == WRITE) begin
                if (last_byte)
                    busy_r <= 1'b0;
                else
                    idx <= idx + 8'd1;
            end
        end
    end

    // NOTE: default assignment first so no path leaves state_nx unassigned and infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (trigger) state_nx = FIRST;
`ifdef OAM_DMA_ALIGN_EN
            ALIGN: state_nx = align_stay ? ALIGN : READ;
`endif
            READ:  state_nx = WRITE;
            WRITE: state_nx = last_byte ? IDLE : READ;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_address = bus.cpu_address;
        bus.mem_o_data  = bus.cpu_o_data;
        bus.mem_we      = bus.cpu_we;
        bus.cpu_i_data  = bus.mem_i_data;
        bus.cpu_locked  = locked & ~busy_r;
        bus.busy        = busy_r;
        case (state)
`ifdef OAM_DMA_ALIGN_EN
            ALIGN: begin
                bus.mem_address = {page, 8'h00};
                bus.mem_we      = 1'b0;
            end
`endif
            READ: begin
                bus.mem_address = {page, idx};
                bus.mem_we      = 1'b0;
            end
            WRITE: begin
                bus.mem_address = OAM_PORT;
                bus.mem_o_data  = bus.mem_i_data;
                bus.mem_we      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: randomized CPU traffic and transfers checked every cycle against a
// transfer-level model (step count within the copy), plus directed literal checks.
module tb_oam_dma;

    localparam int BASE_FREEZE = 512;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic locked = 1'b1;

    oam_dma_if bus ();

    oam_dma dut (
        .clock  (clock),
        .reset  (reset),
        .locked (locked),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int oam_base = 0;

    logic [7:0] mem_arr [65536];
    logic [7:0] oam_q [$];

    bit         m_active = 1'b0;
    int         m_step   = 0;
    logic [7:0] m_page   = 8'h00;
    bit         m_weq    = 1'b0;
    bit         m_par    = 1'b0;
    int         m_align  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int align_len(input bit par_before);
`ifdef OAM_DMA_ALIGN_EN
        return par_before ? 1 : 2;
`else
        return (par_before === 1'bx) ? 1 : 0;
`endif
    endfunction

    // Transfer-level model: m_step counts enabled cycles since the trigger edge.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_step   <= 0;
            m_page   <= 8'h00;
            m_weq    <= 1'b0;
            m_par    <= 1'b0;
            m_align  <= 0;
        end else if (locked) begin
            m_weq <= bus.cpu_we;
            m_par <= ~m_par;
            if (m_active) begin
                if (m_step == BASE_FREEZE + m_align)
                    m_active <= 1'b0;
                else
                    m_step <= m_step + 1;
            end else if (bus.cpu_we && !m_weq && bus.cpu_address == 16'h4014) begin
                m_active <= 1'b1;
                m_step   <= 1;
                m_page   <= bus.cpu_o_data;
                m_align  <= align_len(m_par);
            end
        end
    end

    // NOTE: the memory array has no reset; the stimulus loads its contents before use.
    always @(posedge clock)
        if (locked)
            bus.mem_i_data <= mem_arr[bus.mem_address];

    always @(posedge clock)
        if (locked && !reset && bus.mem_we && bus.mem_address == 16'h2004)
            oam_q.push_back(bus.mem_o_data);

    always @(negedge clock) begin
        logic [15:0] ea;
        logic        ewe;
        logic [7:0]  ed;
        int          s;
        ea  = 16'h0000;
        ewe = 1'b0;
        ed  = 8'h00;
        check("busy", 32'(bus.busy), 32'(m_active));
        check("cpu_locked", 32'(bus.cpu_locked), 32'(locked & ~m_active));
        check("cpu_i_data", 32'(bus.cpu_i_data), 32'(bus.mem_i_data));
        if (!m_active) begin
            check("pass_addr", 32'(bus.mem_address), 32'(bus.cpu_address));
            check("pass_data", 32'(bus.mem_o_data), 32'(bus.cpu_o_data));
            check("pass_we", 32'(bus.mem_we), 32'(bus.cpu_we));
        end else begin
            if (m_step <= m_align) begin
                ea = {m_page, 8'h00};
            end else begin
                s = m_step - m_align;
                if (s % 2 == 1) begin
                    ea = {m_page, 8'((s - 1) / 2)};
                end else begin
                    ea  = 16'h2004;
                    ewe = 1'b1;
                    ed  = mem_arr[{m_page, 8'((s - 2) / 2)}];
                end
            end
            check("dma_addr", 32'(bus.mem_address), 32'(ea));
            check("dma_we", 32'(bus.mem_we), 32'(ewe));
            if (ewe)
                check("dma_data", 32'(bus.mem_o_data), 32'(ed));
        end
    end

    task automatic rand_cpu();
        logic [15:0] a;
        do a = 16'($urandom); while (a == 16'h4014 || a == 16'h2004);
        bus.cpu_address = a;
        bus.cpu_o_data  = 8'($urandom);
        bus.cpu_we      = 1'($urandom);
    endtask

    task automatic idle_traffic(input int n);
        repeat (n) begin
            @(posedge clock); #2;
            rand_cpu();
        end
        @(posedge clock); #2;
        bus.cpu_we = 1'b0;
    endtask

    task automatic trigger_dma(input logic [7:0] pg, input bit want_par, input bit hold, output int exp_freeze);
        @(posedge clock); #2;
        bus.cpu_we      = 1'b0;
        bus.cpu_address = 16'h0000;
        do begin
            @(posedge clock); #2;
        end while (m_par != want_par);
        exp_freeze      = BASE_FREEZE + align_len(want_par);
        oam_base        = oam_q.size();
        bus.cpu_address = 16'h4014;
        bus.cpu_o_data  = pg;
        bus.cpu_we      = 1'b1;
        @(posedge clock); #2;
        if (!hold) begin
            bus.cpu_we      = 1'b0;
            bus.cpu_address = 16'h1234;
            bus.cpu_o_data  = 8'h00;
        end
    endtask

    task automatic run_transfer(input logic [7:0] pg, input int stall_at, input int reset_at, output int frozen);
        int stall_left;
        bit stalled;
        stall_left = 0;
        stalled    = 1'b0;
        frozen     = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            if (bus.cpu_locked && stall_left == 0)
                return;
            frozen++;
            if (stall_left > 0) begin
                check("stall_addr", 32'(bus.mem_address), 32'({pg, 8'(stall_at)}));
                stall_left--;
                if (stall_left == 0) begin
                    #2 locked = 1'b1;
                end
            end else if (!stalled && stall_at >= 0 && oam_q.size() - oam_base == stall_at) begin
                stalled = 1'b1;
                check("stall_addr", 32'(bus.mem_address), 32'({pg, 8'(stall_at)}));
                #2 locked = 1'b0;
                stall_left = 10;
            end else if (reset_at >= 0 && oam_q.size() - oam_base == reset_at) begin
                #2;
                reset      = 1'b1;
                bus.cpu_we = 1'b0;
                #1;
                check("rst_busy", 32'(bus.busy), 32'd0);
                check("rst_cpu_locked", 32'(bus.cpu_locked), 32'd1);
                check("rst_mirror", 32'(bus.mem_address), 32'(bus.cpu_address));
                @(posedge clock); #2;
                reset  = 1'b0;
                frozen = -1;
                return;
            end
        end
        check("transfer_timeout", 32'(bus.cpu_locked), 32'd1);
    endtask

    initial begin
        int         fr;
        int         ef;
        int         st;
        logic [7:0] pg;

        for (int a = 0; a < 65536; a++)
            mem_arr[a] = 8'($urandom);
        for (int i = 0; i < 256; i++)
            mem_arr[16'h0200 + i] = 8'(i) ^ 8'hA5;

        bus.cpu_address = 16'hBEEF;
        bus.cpu_o_data  = 8'h00;
        bus.cpu_we      = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_cpu_locked", 32'(bus.cpu_locked), 32'd1);
        check("reset_mirror", 32'(bus.mem_address), 32'h0000BEEF);
        reset = 1'b0;

        idle_traffic(20);

        @(posedge clock); #2;
        bus.cpu_address = 16'h0300;
        bus.cpu_o_data  = 8'h5A;
        bus.cpu_we      = 1'b1;
        #1;
        check("pt_addr", 32'(bus.mem_address), 32'h00000300);
        check("pt_data", 32'(bus.mem_o_data), 32'h0000005A);
        check("pt_we", 32'(bus.mem_we), 32'd1);
        check("pt_busy", 32'(bus.busy), 32'd0);
        @(posedge clock); #2;
        bus.cpu_we = 1'b0;

        trigger_dma(8'h02, 1'b1, 1'b0, ef);
        run_transfer(8'h02, -1, -1, fr);
        check("full_freeze", 32'(fr), 32'(ef));
        check("full_count", 32'(oam_q.size() - oam_base), 32'd256);
        for (int i = 0; i < 256; i++)
            check("full_byte", 32'(oam_q[oam_base + i]), 32'(8'(i) ^ 8'hA5));

        trigger_dma(8'h03, 1'b0, 1'b1, ef);
        run_transfer(8'h03, -1, -1, fr);
        check("hold_freeze", 32'(fr), 32'(ef));
        repeat (30) @(negedge clock);
        check("hold_busy", 32'(bus.busy), 32'd0);
        check("hold_count", 32'(oam_q.size() - oam_base), 32'd256);
        @(posedge clock); #2;
        bus.cpu_we = 1'b0;

        pg = 8'($urandom);
        trigger_dma(pg, 1'b1, 1'b0, ef);
        run_transfer(pg, 100, -1, fr);
        check("stall_freeze", 32'(fr), 32'(ef + 10));
        check("stall_count", 32'(oam_q.size() - oam_base), 32'd256);

        pg = 8'hFF;
        trigger_dma(pg, 1'b1, 1'b0, ef);
        run_transfer(pg, -1, 37, fr);
        check("rst_partial", 32'(oam_q.size() - oam_base), 32'd37);
        idle_traffic(5);
        trigger_dma(pg, 1'b1, 1'b0, ef);
        run_transfer(pg, -1, -1, fr);
        check("retrig_freeze", 32'(fr), 32'(ef));
        check("retrig_count", 32'(oam_q.size() - oam_base), 32'd256);
        check("retrig_first", 32'(oam_q[oam_base]), 32'(mem_arr[16'hFF00]));
        check("retrig_last", 32'(oam_q[oam_base + 255]), 32'(mem_arr[16'hFFFF]));

        trigger_dma(8'h10, 1'b1, 1'b0, ef);
        run_transfer(8'h10, -1, -1, fr);
`ifdef OAM_DMA_ALIGN_EN
        check("freeze_513", 32'(fr), 32'd513);
`else
        check("freeze_512a", 32'(fr), 32'd512);
`endif
        trigger_dma(8'h11, 1'b0, 1'b0, ef);
        run_transfer(8'h11, -1, -1, fr);
`ifdef OAM_DMA_ALIGN_EN
        check("freeze_514", 32'(fr), 32'd514);
`else
        check("freeze_512b", 32'(fr), 32'd512);
`endif

        repeat (6) begin
            idle_traffic(5 + int'($urandom_range(35)));
            pg = 8'($urandom);
            st = ($urandom_range(1) == 1) ? int'($urandom_range(254, 1)) : -1;
            trigger_dma(pg, 1'($urandom), 1'b0, ef);
            run_transfer(pg, st, -1, fr);
            check("rand_freeze", 32'(fr), 32'(ef + ((st >= 0) ? 10 : 0)));
            check("rand_count", 32'(oam_q.size() - oam_base), 32'd256);
        end

        idle_traffic(10);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
